// File: rtl/exec_pipe.sv
// exec_pipe: two-stage (EX, WB) integer execute pipeline with a NREG x WIDTH register file.
// Define EXEC_FWD_EN for operand bypassing; without it, RAW hazards stall issue.
module exec_pipe #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               alu_ctr,
  input  logic [$clog2(NREG)-1:0]  rs,
  input  logic [$clog2(NREG)-1:0]  rt,
  input  logic [$clog2(NREG)-1:0]  rd,
  input  logic                     reg_dst,
  input  logic                     reg_write,
  input  logic                     alu_src,
  input  logic [WIDTH-1:0]         imm,
  output logic                     wb_valid,
  output logic [$clog2(NREG)-1:0]  wb_addr,
  output logic [WIDTH-1:0]         wb_data,
  output logic                     wb_v,
  output logic                     wb_zero,
  input  logic [$clog2(NREG)-1:0]  dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);
  localparam int AW = $clog2(NREG);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] rf_d [NREG];

  logic             ex_valid_q, ex_valid_d;
  logic             ex_rw_q,    ex_rw_d;
  logic [3:0]       ex_op_q,    ex_op_d;
  logic [WIDTH-1:0] ex_a_q,     ex_a_d;
  logic [WIDTH-1:0] ex_b_q,     ex_b_d;
  logic [AW-1:0]    ex_dst_q,   ex_dst_d;

  logic             wb_valid_q, wb_valid_d;
  logic [AW-1:0]    wb_addr_q,  wb_addr_d;
  logic [WIDTH-1:0] wb_data_q,  wb_data_d;
  logic             wb_v_q,     wb_v_d;
  logic             wb_zero_q,  wb_zero_d;

  logic [WIDTH-1:0] alu_res, sum, diff;
  logic             alu_v, alu_zero, alu_known;

  logic [WIDTH-1:0] rf_a, rf_b, op_a, op_rt, op_b;
  logic [AW-1:0]    dst;
  logic             hit_ex_a, hit_ex_b, hit_wb_a, hit_wb_b, accept;

  // Entry 0 is never written, so it stays zero from reset onward.
  assign rf_a     = rf_q[rs];
  assign rf_b     = rf_q[rt];
  assign dbg_data = rf_q[dbg_addr];

  always_comb begin
    sum       = ex_a_q + ex_b_q;
    diff      = ex_a_q - ex_b_q;
    alu_res   = '0;
    alu_v     = 1'b0;
    alu_known = 1'b1;
    case (ex_op_q)
      OP_AND: alu_res = ex_a_q & ex_b_q;
      OP_OR:  alu_res = ex_a_q | ex_b_q;
      OP_ADD: begin
        alu_res = sum;
        alu_v   = (ex_a_q[WIDTH-1] == ex_b_q[WIDTH-1]) && (sum[WIDTH-1] != ex_a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_v   = (ex_a_q[WIDTH-1] != ex_b_q[WIDTH-1]) && (diff[WIDTH-1] != ex_a_q[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(ex_a_q) < $signed(ex_b_q))};
      OP_NOR: alu_res = ~(ex_a_q | ex_b_q);
      default: alu_known = 1'b0;
    endcase
    alu_zero = alu_known && (alu_res == '0);
  end

  // Producers with dest 0 never match, so r0 readers are never stalled or bypassed.
  assign hit_ex_a = ex_valid_q && ex_rw_q && (ex_dst_q != '0) && (ex_dst_q == rs);
  assign hit_ex_b = ex_valid_q && ex_rw_q && (ex_dst_q != '0) && (ex_dst_q == rt);
  assign hit_wb_a = wb_valid_q && (wb_addr_q != '0) && (wb_addr_q == rs);
  assign hit_wb_b = wb_valid_q && (wb_addr_q != '0) && (wb_addr_q == rt);

`ifdef EXEC_FWD_EN
  always_comb begin
    op_a  = hit_ex_a ? alu_res : (hit_wb_a ? wb_data_q : rf_a);
    op_rt = hit_ex_b ? alu_res : (hit_wb_b ? wb_data_q : rf_b);
  end
  assign in_ready = !RST;
`else
  assign op_a  = rf_a;
  assign op_rt = rf_b;
  assign in_ready = !RST && !(in_valid &&
                    (hit_ex_a || hit_wb_a || (!alu_src && (hit_ex_b || hit_wb_b))));
`endif

  assign op_b   = alu_src ? imm : op_rt;
  assign dst    = reg_dst ? rd : rt;
  assign accept = in_valid && in_ready;

  always_comb begin
    ex_valid_d = accept;
    ex_rw_d    = ex_rw_q;
    ex_op_d    = ex_op_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_dst_d   = ex_dst_q;
    if (accept) begin
      ex_rw_d  = reg_write;
      ex_op_d  = alu_ctr;
      ex_a_d   = op_a;
      ex_b_d   = op_b;
      ex_dst_d = dst;
    end
    wb_valid_d = ex_valid_q && ex_rw_q;
    wb_addr_d  = ex_valid_q ? ex_dst_q : '0;
    wb_data_d  = ex_valid_q ? alu_res : '0;
    wb_v_d     = ex_valid_q && alu_v;
    wb_zero_d  = ex_valid_q && alu_zero;
    rf_d = rf_q;
    if (wb_valid_q && (wb_addr_q != '0)) rf_d[wb_addr_q] = wb_data_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      ex_valid_q <= 1'b0;
      ex_rw_q    <= 1'b0;
      ex_op_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_dst_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_v_q     <= 1'b0;
      wb_zero_q  <= 1'b0;
    end else begin
      rf_q       <= rf_d;
      ex_valid_q <= ex_valid_d;
      ex_rw_q    <= ex_rw_d;
      ex_op_q    <= ex_op_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_dst_q   <= ex_dst_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_v_q     <= wb_v_d;
      wb_zero_q  <= wb_zero_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign wb_v     = wb_v_q;
  assign wb_zero  = wb_zero_q;

endmodule

// File: tb/tb_exec_pipe.sv
// Directed bench for exec_pipe: default 32x32 instance plus a 16-bit / 8-register instance.
module tb_exec_pipe;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] SLT = 4'b0111;
  localparam logic [3:0] AND = 4'b0000;
  localparam logic [3:0] OR  = 4'b0001;
  localparam logic [3:0] NOR = 4'b1100;
  localparam logic [3:0] BAD = 4'b0011;
`ifdef EXEC_FWD_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 2;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic        in_valid = 0, in_ready, reg_dst = 0, reg_write = 0, alu_src = 0;
  logic [3:0]  alu_ctr = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, dbg_addr = '0, wb_addr;
  logic [31:0] imm = '0, wb_data, dbg_data;
  logic        wb_valid, wb_v, wb_zero;

  logic        in_valid_s = 0, in_ready_s, reg_dst_s = 0, reg_write_s = 0, alu_src_s = 0;
  logic [3:0]  alu_ctr_s = '0;
  logic [2:0]  rs_s = '0, rt_s = '0, rd_s = '0, dbg_addr_s = '0, wb_addr_s;
  logic [15:0] imm_s = '0, wb_data_s, dbg_data_s;
  logic        wb_valid_s, wb_v_s, wb_zero_s;

  int n_cmp = 0;
  int n_bad = 0;
  int st;

  exec_pipe u0 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .alu_ctr(alu_ctr),
    .rs(rs), .rt(rt), .rd(rd), .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src),
    .imm(imm), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_v(wb_v),
    .wb_zero(wb_zero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  exec_pipe #(.WIDTH(16), .NREG(8)) u1 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid_s), .in_ready(in_ready_s), .alu_ctr(alu_ctr_s),
    .rs(rs_s), .rt(rt_s), .rd(rd_s), .reg_dst(reg_dst_s), .reg_write(reg_write_s),
    .alu_src(alu_src_s), .imm(imm_s), .wb_valid(wb_valid_s), .wb_addr(wb_addr_s),
    .wb_data(wb_data_s), .wb_v(wb_v_s), .wb_zero(wb_zero_s), .dbg_addr(dbg_addr_s),
    .dbg_data(dbg_data_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] b1(input logic v);
    return {31'b0, v};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Present one instruction, count stalled cycles, return 1ns after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [4:0] a_rs, input logic [4:0] a_rt,
                       input logic [4:0] a_rd, input logic a_dst, input logic a_we,
                       input logic a_src, input logic [31:0] a_imm, output int n_stall);
    alu_ctr = op; rs = a_rs; rt = a_rt; rd = a_rd;
    reg_dst = a_dst; reg_write = a_we; alu_src = a_src; imm = a_imm;
    in_valid = 1'b1;
    n_stall = 0;
    @(negedge CLK);
    for (int k = 0; k < 20 && !in_ready; k++) begin
      @(negedge CLK);
      n_stall++;
    end
    chk("issue_ready", b1(in_ready), 32'd1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0; alu_ctr = '0; rs = '0; rt = '0; rd = '0;
    reg_dst = 1'b0; reg_write = 1'b0; alu_src = 1'b0; imm = '0;
  endtask

  task automatic issue_s(input logic [3:0] op, input logic [2:0] a_rs, input logic [2:0] a_rt,
                         input logic [2:0] a_rd, input logic a_dst, input logic [15:0] a_imm,
                         input logic a_src);
    alu_ctr_s = op; rs_s = a_rs; rt_s = a_rt; rd_s = a_rd;
    reg_dst_s = a_dst; reg_write_s = 1'b1; alu_src_s = a_src; imm_s = a_imm;
    in_valid_s = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 20 && !in_ready_s; k++) @(negedge CLK);
    chk("issue_ready_s", b1(in_ready_s), 32'd1);
    @(posedge CLK);
    #1;
    in_valid_s = 1'b0; alu_ctr_s = '0; rs_s = '0; rt_s = '0; rd_s = '0;
    reg_dst_s = 1'b0; reg_write_s = 1'b0; alu_src_s = 1'b0; imm_s = '0;
  endtask

  task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string tag);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic peek_s(input logic [2:0] a, input logic [15:0] exp, input string tag);
    dbg_addr_s = a;
    #1;
    chk(tag, {16'b0, dbg_data_s}, {16'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #3;
    chk("rst_in_ready", b1(in_ready), 32'd0);
    chk("rst_wb_valid", b1(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_addr", {27'b0, wb_addr}, 32'd0);
    chk("rst_wb_flags", {30'b0, wb_v, wb_zero}, 32'd0);
    peek(5'd5, 32'd0, "rst_dbg_r5");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("ready_after_rst", b1(in_ready), 32'd1);

    // r1=5, r2=7 via immediate adds into rt
    issue(ADD, 5'd0, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 32'd5, st);
    issue(ADD, 5'd0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 32'd7, st);
    tick(3);
    peek(5'd1, 32'd5, "r1_init");
    peek(5'd2, 32'd7, "r2_init");

    // latency: ADD r3 = r1 + r2
    issue(ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'd0, st);
    chk("lat_ex_wb_valid", b1(wb_valid), 32'd0);
    tick(1);
    chk("lat_wb_valid", b1(wb_valid), 32'd1);
    chk("lat_wb_addr", {27'b0, wb_addr}, 32'd3);
    chk("lat_wb_data", wb_data, 32'd12);
    peek(5'd3, 32'd0, "lat_r3_before_write");
    tick(1);
    peek(5'd3, 32'd12, "lat_r3_written");
    chk("lat_wb_valid_after", b1(wb_valid), 32'd0);

    // back-to-back dependency: r5 = r1 + r2 ; r4 = r5 - r1
    issue(ADD, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 32'd0, st);
    chk("b2b_first_stall", st, 32'd0);
    issue(SUB, 5'd5, 5'd1, 5'd4, 1'b1, 1'b1, 1'b0, 32'd0, st);
    chk("b2b_stall_cycles", st, EXP_STALL);
    tick(3);
    peek(5'd4, 32'd7, "b2b_r4");
    peek(5'd5, 32'd12, "b2b_r5");

    // flags
    issue(ADD, 5'd0, 5'd6, 5'd0, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, st);
    issue(ADD, 5'd6, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 32'd1, st);
    tick(1);
    chk("add_ovf_data", wb_data, 32'h8000_0000);
    chk("add_ovf_v", b1(wb_v), 32'd1);
    chk("add_ovf_zero", b1(wb_zero), 32'd0);
    chk("add_ovf_addr", {27'b0, wb_addr}, 32'd7);
    issue(SUB, 5'd1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 32'd5, st);
    tick(1);
    chk("sub_zero_data", wb_data, 32'd0);
    chk("sub_zero_z", b1(wb_zero), 32'd1);
    chk("sub_zero_v", b1(wb_v), 32'd0);
    issue(SUB, 5'd7, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 32'd1, st);
    tick(1);
    chk("sub_ovf_data", wb_data, 32'h7FFF_FFFF);
    chk("sub_ovf_v", b1(wb_v), 32'd1);
    issue(ADD, 5'd0, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, st);
    issue(SLT, 5'd9, 5'd10, 5'd0, 1'b0, 1'b1, 1'b1, 32'd1, st);
    tick(1);
    chk("slt_neg_lt_pos", wb_data, 32'd1);
    issue(SLT, 5'd1, 5'd10, 5'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, st);
    tick(1);
    chk("slt_pos_lt_neg", wb_data, 32'd0);
    chk("slt_pos_lt_neg_z", b1(wb_zero), 32'd1);

    // logic ops and unknown opcode on r1 = 5
    issue(AND, 5'd1, 5'd11, 5'd0, 1'b0, 1'b1, 1'b1, 32'hC, st);
    tick(1);
    chk("and", wb_data, 32'd4);
    issue(OR, 5'd1, 5'd11, 5'd0, 1'b0, 1'b1, 1'b1, 32'hA, st);
    tick(1);
    chk("or", wb_data, 32'hF);
    issue(NOR, 5'd1, 5'd11, 5'd0, 1'b0, 1'b1, 1'b1, 32'd0, st);
    tick(1);
    chk("nor", wb_data, 32'hFFFF_FFFA);
    issue(BAD, 5'd1, 5'd11, 5'd0, 1'b0, 1'b1, 1'b1, 32'd3, st);
    tick(1);
    chk("bad_op_data", wb_data, 32'd0);
    chk("bad_op_flags", {30'b0, wb_v, wb_zero}, 32'd0);

    // reg_write=0 leaves the file untouched
    issue(ADD, 5'd1, 5'd12, 5'd0, 1'b0, 1'b0, 1'b1, 32'd1, st);
    tick(1);
    chk("nowrite_wb_valid", b1(wb_valid), 32'd0);
    tick(2);
    peek(5'd12, 32'd0, "nowrite_r12");

    // r0: write discarded, readers never stall
    issue(ADD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 32'hDEAD, st);
    issue(ADD, 5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 1'b0, 32'd0, st);
    chk("r0_reader_stall", st, 32'd0);
    chk("r0_wb_valid", b1(wb_valid), 32'd1);
    chk("r0_wb_addr", {27'b0, wb_addr}, 32'd0);
    chk("r0_wb_data", wb_data, 32'hDEAD);
    tick(1);
    chk("r0_reader_data", wb_data, 32'd0);
    chk("r0_reader_addr", {27'b0, wb_addr}, 32'd13);
    peek(5'd0, 32'd0, "r0_reads_zero");

    // reset mid-stream with ADD r14 in EX
    issue(ADD, 5'd1, 5'd2, 5'd14, 1'b1, 1'b1, 1'b0, 32'd0, st);
    RST = 1'b1;
    #1;
    chk("midrst_wb_valid", b1(wb_valid), 32'd0);
    chk("midrst_in_ready", b1(in_ready), 32'd0);
    for (int a = 0; a < 32; a++) peek(a[4:0], 32'd0, "midrst_rf_clear");
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    tick(3);
    peek(5'd14, 32'd0, "midrst_r14");
    chk("midrst_wb_valid_after", b1(wb_valid), 32'd0);

    // 16-bit, 8-register instance
    issue_s(ADD, 3'd0, 3'd7, 3'd0, 1'b0, 16'hFFFF, 1'b1);
    tick(3);
    peek_s(3'd7, 16'hFFFF, "w16_r7_init");
    issue_s(ADD, 3'd7, 3'd6, 3'd0, 1'b0, 16'd1, 1'b1);
    tick(1);
    chk("w16_wrap_data", {16'b0, wb_data_s}, 32'd0);
    chk("w16_wrap_zero", b1(wb_zero_s), 32'd1);
    chk("w16_wrap_v", b1(wb_v_s), 32'd0);
    chk("w16_wrap_addr", {29'b0, wb_addr_s}, 32'd6);
    issue_s(ADD, 3'd0, 3'd0, 3'd7, 1'b1, 16'h1234, 1'b1);
    tick(2);
    peek_s(3'd7, 16'h1234, "w16_rd7");
    peek_s(3'd6, 16'h0000, "w16_r6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exec_pipe.md
EXEC_PIPE -- requirements
Module: exec_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath and register width in bits (>=8).
REQ-002 The block SHALL have parameter NREG, default 32, number of architectural registers (power of two, >=4); AW = log2(NREG) is derived internally.
REQ-003 The block SHALL have port CLK  input  1  the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  issue request carrying one decoded instruction.
REQ-006 The block SHALL have port in_ready  output  1  block accepts the instruction at this edge.
REQ-007 The block SHALL have ports alu_ctr  input  4, rs/rt/rd  input  AW, reg_dst/reg_write/alu_src  input  1, imm  input  WIDTH  (already extended): decoded fields.
REQ-008 The block SHALL have ports wb_valid  output  1, wb_addr  output  AW, wb_data  output  WIDTH, wb_v  output  1, wb_zero  output  1: writeback-stage contents.
REQ-009 The block SHALL have ports dbg_addr  input  AW and dbg_data  output  WIDTH: combinational register-file read for observation.

Function
REQ-010 Issue handshake: instruction accepted on a rising edge where in_valid && in_ready; inputs are ignored otherwise.
REQ-011 Pipeline SHALL be EX register (operands, dest, controls) then WB register (result, dest, flags); accepted at edge N -> wb_* valid during cycle N+1..N+2 -> register file written at edge N+2.
REQ-012 Dest = reg_dst ? rd : rt; operand A = R[rs]; operand B = alu_src ? imm : R[rt].
REQ-013 ALU ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0 zero-extended), 1100 NOR; any other code -> result 0, flags 0.
REQ-014 Arithmetic modulo 2^WIDTH; wb_v = signed overflow for ADD/SUB only, else 0; wb_zero = (result == 0).
REQ-015 Register 0 SHALL read as 0 always; writes to address 0 discarded; dest 0 never creates a hazard.
REQ-016 wb_valid SHALL be 1 only for an accepted instruction with reg_write=1 in the WB stage; bubbles and reg_write=0 instructions give wb_valid=0.
REQ-017 dbg_data = R[dbg_addr] combinationally, reflecting the write of edge N+2 from that edge onward.
REQ-018 Hazard: an issuing instruction whose rs (or rt when alu_src=0) equals a nonzero dest held with reg_write=1 in EX or WB stage; handled per REQ-023/024.
REQ-019 When in_valid && !in_ready, a bubble (valid=0) enters EX; WB advances every cycle (no output backpressure).

Reset
REQ-020 While RST=1: all registers R[0..NREG-1] = 0, EX and WB valid = 0, in_ready = 0, wb_valid/wb_addr/wb_data/wb_v/wb_zero = 0.
REQ-021 RST asserted mid-operation SHALL discard all in-flight instructions; none of them writes the register file.
REQ-022 First acceptance possible at the first rising edge after RST deasserts.

Configuration
REQ-023 With macro EXEC_FWD_EN defined: operands bypass from the EX-stage ALU result (highest priority) then WB-stage result, before the register file; in_ready = 1 whenever RST=0; no stalls.
REQ-024 Without EXEC_FWD_EN: in_ready = 0 while any hazard (REQ-018) exists, inserting bubbles until the producer has written the register file; results are identical to the forwarded build, only timing differs.

Verification
REQ-025 Reset: RST pulse mid-stream with ADD in flight -> wb_valid=0, dbg_data=0 for all addresses, dest register stays 0 after release.
REQ-026 Latency: R1=5,R2=7 via ADDI-style (alu_src=1); issue ADD rd=3 rs=1 rt=2 at edge N -> wb_data=12, wb_addr=3 in cycle N+1; dbg_addr=3 reads 12 after edge N+2.
REQ-027 Back-to-back dependency: ADD r3=r1+r2 then SUB r4=r3-r1 (r1=5,r2=7) -> r4=7; with EXEC_FWD_EN in_ready stays 1; without, in_ready=0 for exactly 2 cycles.
REQ-028 Flags (WIDTH=32): ADD 0x7FFFFFFF+1 -> wb_data=0x80000000, wb_v=1; SUB 5-5 -> wb_zero=1, wb_v=0; SLT -1,1 -> wb_data=1.
REQ-029 Register 0: write rd=0 with 0xDEAD -> wb_valid=1 but dbg_addr=0 reads 0; following instruction reading r0 never stalls.
REQ-030 Parameter sweep WIDTH=16, NREG=8: ADD 0xFFFF+1 -> wb_data=0, wb_zero=1; rd=7 writes land at R[7].
